pll_ratio_monitor: RTL



---
 rtl/pll_mon_pkg.sv | 25 ++
 rtl/sync_edge_det.sv | 26 ++
 rtl/pll_ratio_monitor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pll_mon_pkg.sv
// Shared state encoding, default constants and width helper for the PLL ratio monitor.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        PLL_RST = 2'd0,
        TRAIN   = 2'd1,
        LOCKED  = 2'd2
    } pll_state_e;

    localparam int RATIO_DEF      = 14;
    localparam int TOL_DEF        = 1;
    localparam int TIMEOUT_DEF    = 64;
    localparam int GOOD_COUNT_DEF = 16;
    localparam int RST_CYCLES_DEF = 32;

    function automatic int pll_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a history flop; emits a one-cycle pulse on a rising
// edge of an asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1, r_sync2, r_sync3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/pll_ratio_monitor.sv
// Lock supervisor for the system PLL: measures reference periods in fast-clock cycles
// and drives pll_reset/locked. Define PLL_MON_PHASE_EN to build the phase counter.
module pll_ratio_monitor
    import pll_mon_pkg::*;
#(
    parameter int RATIO      = RATIO_DEF,
    parameter int TOL        = TOL_DEF,
    parameter int GOOD_COUNT = GOOD_COUNT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ref_clk_i,
    output logic                              pll_reset,
    output logic                              locked,
    output logic [3:0]                        phase,
    output logic [pll_clog2(TIMEOUT+1)-1:0]   period,
    output logic [7:0]                        err_count
);

    localparam int CW = pll_clog2(TIMEOUT + 1);
    localparam int GW = pll_clog2(GOOD_COUNT + 1);
    localparam int RW = pll_clog2(RST_CYCLES + 1);

    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_LO      = CW'(RATIO - TOL);
    localparam logic [CW-1:0] C_HI      = CW'(RATIO + TOL);
    localparam logic [GW-1:0] C_GOOD_M1 = GW'(GOOD_COUNT - 1);
    localparam logic [RW-1:0] C_RST_M1  = RW'(RST_CYCLES - 1);

    pll_state_e      r_state, w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_period;
    logic [RW-1:0]   r_rst_cnt;
    logic [GW-1:0]   r_good;
    logic [7:0]      r_err_count;
    logic            r_first_seen;
    logic            r_locked;
    logic            r_pll_reset;

    logic            w_edge;
    logic [CW-1:0]   w_meas;
    logic            w_meas_ok;
    logic            w_judge;
    logic            w_timeout;
    logic            w_locked_d;
    logic            w_pll_reset_d;
    logic            w_lock_lost;

    sync_edge_det u_ref_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (ref_clk_i),
        .o_rise  (w_edge)
    );

    // Period ends on the edge cycle itself, hence cnt+1; a saturated counter reads as TIMEOUT.
    assign w_meas    = (r_cnt == C_TIMEOUT) ? C_TIMEOUT : r_cnt + CW'(1);
    assign w_meas_ok = (w_meas >= C_LO) && (w_meas <= C_HI);
    assign w_judge   = w_edge && r_first_seen && (r_state != PLL_RST);
    assign w_timeout = !w_edge && (r_cnt == C_TIMEOUT) && (r_state != PLL_RST);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= PLL_RST;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            PLL_RST: if (r_rst_cnt == '0) w_next_state = TRAIN;
            TRAIN: begin
                if (w_timeout)
                    w_next_state = PLL_RST;
                else if (w_judge && w_meas_ok && r_good == C_GOOD_M1)
                    w_next_state = LOCKED;
            end
            LOCKED: if (w_timeout || (w_judge && !w_meas_ok)) w_next_state = PLL_RST;
            default: w_next_state = PLL_RST;
        endcase
    end

    // pll_reset follows the state one cycle late so it rises just after locked falls.
    always_comb begin
        w_locked_d    = (w_next_state == LOCKED);
        w_pll_reset_d = (r_state == PLL_RST);
        w_lock_lost   = (r_state == LOCKED) && (w_next_state == PLL_RST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_locked     <= 1'b0;
            r_pll_reset  <= 1'b1;
            r_cnt        <= '0;
            r_period     <= '0;
            r_rst_cnt    <= C_RST_M1;
            r_good       <= '0;
            r_first_seen <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_locked    <= w_locked_d;
            r_pll_reset <= w_pll_reset_d;
            if (r_state == PLL_RST) begin
                r_cnt        <= '0;
                r_good       <= '0;
                r_first_seen <= 1'b0;
                if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - RW'(1);
            end else begin
                r_rst_cnt <= C_RST_M1;
                if (w_edge) begin
                    r_cnt        <= '0;
                    r_first_seen <= 1'b1;
                end else if (r_cnt != C_TIMEOUT) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                // A timeout reports the saturated count as the last period.
                if (w_judge) begin
                    r_period <= w_meas;
                    if (r_state == TRAIN) r_good <= w_meas_ok ? r_good + GW'(1) : '0;
                end else if (w_timeout) begin
                    r_period <= C_TIMEOUT;
                end
            end
            if (w_lock_lost && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

`ifdef PLL_MON_PHASE_EN
    logic [3:0] r_phase;

    always_ff @(posedge clk) begin
        if (!reset_n)                     r_phase <= 4'd0;
        else if (w_edge)                  r_phase <= 4'd0;
        else if (r_phase == 4'(RATIO-1))  r_phase <= 4'd0;
        else                              r_phase <= r_phase + 4'd1;
    end

    assign phase = r_phase;
`else
    assign phase = 4'd0;
`endif

    assign locked    = r_locked;
    assign pll_reset = r_pll_reset;
    assign period    = r_period;
    assign err_count = r_err_count;

endmodule
